// File: rtl/alu_pipelined.sv
// Handshaked RV32I-style ALU with registered result and branch-compare flags.
// Shifts use a barrel shifter or, with SHIFT_ITER=1, a 1-bit-per-cycle shifter.
module alu_pipelined #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_ITER = 0,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1010;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_AND:  alu_calc = a & b;
            OP_OR:   alu_calc = a | b;
            OP_ADD:  alu_calc = a + b;
            OP_XOR:  alu_calc = a ^ b;
            OP_SLL:  alu_calc = a << sh;
            OP_SRL:  alu_calc = a >> sh;
            OP_SUB:  alu_calc = a - b;
            OP_SRA:  alu_calc = $unsigned($signed(a) >>> sh);
            OP_SLT:  alu_calc = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_calc = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASS: alu_calc = b;
            default: alu_calc = {WIDTH{1'b0}};
        endcase
    endfunction

    // One iteration of the serial shifter in the direction of the opcode.
    function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  shift_step = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_step = v;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [SHW-1:0]   cnt_r, cnt_s;
    logic [3:0]       op_r, op_s;
    logic             eq_r, eq_s, lt_r, lt_s, ltu_r, ltu_s;
    logic             out_valid_r, out_valid_s;
    logic             in_ready_s, accept_s, iter_start_s;
    logic [WIDTH-1:0] step_s;

    // Acceptance: idle, or a result leaving this cycle makes room for the next.
    always_comb begin
        in_ready_s = 1'b0;
        if (!reset && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready))) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s     = in_valid && in_ready_s;
    assign iter_start_s = (SHIFT_ITER != 0) && is_shift(select) && (data2[SHW-1:0] != CNT_ZERO);
    assign step_s       = shift_step(op_r, shreg_r);

    // Next-state and next-register computation for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        result_s    = result_r;
        shreg_s     = shreg_r;
        cnt_s       = cnt_r;
        op_s        = op_r;
        eq_s        = eq_r;
        lt_s        = lt_r;
        ltu_s       = ltu_r;
        out_valid_s = out_valid_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    op_s  = select;
                    eq_s  = (data1 == data2);
                    lt_s  = ($signed(data1) < $signed(data2));
                    ltu_s = (data1 < data2);
                    if (iter_start_s) begin
                        shreg_s     = data1;
                        cnt_s       = data2[SHW-1:0];
                        state_s     = ST_SHIFT;
                        out_valid_s = 1'b0;
                    end else begin
                        result_s    = alu_calc(select, data1, data2);
                        cnt_s       = CNT_ZERO;
                        state_s     = ST_DONE;
                        out_valid_s = 1'b1;
                    end
                end else if ((state_r == ST_DONE) && out_ready) begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SHIFT: begin
                // The count holds the shifts still owed, including this cycle's.
                if (cnt_r == CNT_ONE) begin
                    result_s    = step_s;
                    cnt_s       = CNT_ZERO;
                    state_s     = ST_DONE;
                    out_valid_s = 1'b1;
                end else begin
                    shreg_s = step_s;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            result_r    <= {WIDTH{1'b0}};
            shreg_r     <= {WIDTH{1'b0}};
            cnt_r       <= CNT_ZERO;
            op_r        <= 4'b0000;
            eq_r        <= 1'b0;
            lt_r        <= 1'b0;
            ltu_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            result_r    <= result_s;
            shreg_r     <= shreg_s;
            cnt_r       <= cnt_s;
            op_r        <= op_s;
            eq_r        <= eq_s;
            lt_r        <= lt_s;
            ltu_r       <= ltu_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign eq        = eq_r;
    assign lt        = lt_r;
    assign ltu       = ltu_r;

endmodule

// File: tb/tb_alu_pipelined.sv
// Scoreboard bench for alu_pipelined: one iterative-shift instance and one
// barrel-shift instance, exercised in turn with the same directed and random ops.
module tb_alu_pipelined;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] data1 = 32'h0;
    logic [31:0] data2 = 32'h0;
    logic [3:0]  select = 4'h0;
    logic        sel = 1'b1;

    logic        in_ready_i, out_valid_i, eq_i, lt_i, ltu_i;
    logic [31:0] result_i;
    logic        in_ready_b, out_valid_b, eq_b, lt_b, ltu_b;
    logic [31:0] result_b;
    logic        in_valid_i, in_valid_b;

    logic        in_ready_m, out_valid_m, eq_m, lt_m, ltu_m;
    logic [31:0] result_m;

    assign in_valid_i  = in_valid & sel;
    assign in_valid_b  = in_valid & ~sel;
    assign in_ready_m  = sel ? in_ready_i  : in_ready_b;
    assign out_valid_m = sel ? out_valid_i : out_valid_b;
    assign result_m    = sel ? result_i    : result_b;
    assign eq_m        = sel ? eq_i        : eq_b;
    assign lt_m        = sel ? lt_i        : lt_b;
    assign ltu_m       = sel ? ltu_i       : ltu_b;

    alu_pipelined #(.WIDTH(32), .SHIFT_ITER(1)) dut_iter (
        .clk(clk), .reset(reset), .in_valid(in_valid_i), .in_ready(in_ready_i),
        .data1(data1), .data2(data2), .select(select), .out_valid(out_valid_i),
        .out_ready(out_ready), .result(result_i), .eq(eq_i), .lt(lt_i), .ltu(ltu_i)
    );

    alu_pipelined #(.WIDTH(32), .SHIFT_ITER(0)) dut_barrel (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data1(data1), .data2(data2), .select(select), .out_valid(out_valid_b),
        .out_ready(out_ready), .result(result_b), .eq(eq_b), .lt(lt_b), .ltu(ltu_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (iter=%0d) got=%h expected=%h", tag, sel, got, exp);
        end
    endtask

    // Reference: shifts done one bit at a time, signed compare via sign bits.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic iter);
        exp_t        e;
        logic [31:0] r;
        logic        slt;
        int          sh;
        sh  = int'(b[4:0]);
        slt = (a[31] != b[31]) ? a[31] : (a < b);
        r   = a;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a ^ b;
            4'h4: for (int k = 0; k < sh; k++) r = {r[30:0], 1'b0};
            4'h5: for (int k = 0; k < sh; k++) r = {1'b0, r[31:1]};
            4'h6: r = a - b;
            4'h7: for (int k = 0; k < sh; k++) r = {r[31], r[31:1]};
            4'h8: r = {31'h0, slt};
            4'h9: r = {31'h0, (a < b)};
            4'hA: r = b;
            default: r = 32'h0;
        endcase
        e.res   = r;
        e.flags = {(a == b), slt, (a < b)};
        e.acc   = 0;
        e.lat   = (iter && (op == 4'h4 || op == 4'h5 || op == 4'h7) && sh != 0) ? 1 + sh : 1;
        return e;
    endfunction

    // Drive one op, wait (bounded) for acceptance, push the expectation.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit track, output int waits);
        exp_t e;
        select   = op;
        data1    = a;
        data2    = b;
        in_valid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!in_ready_m && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready_m) begin
            chk("accept_timeout", {63'h0, in_ready_m}, 64'h1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        e     = model(op, a, b, sel);
        e.acc = cyc;
        if (!track) e.lat = -1;
        sb.push_back(e);
        in_valid = 1'b0;
        data1    = $urandom;
        data2    = $urandom;
        select   = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        chk("drain", 64'(sb.size()), 64'h0);
    endtask

    // Scoreboard check at every completed output handshake.
    always @(negedge clk) begin
        if (out_valid_m && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {63'h0, out_valid_m}, 64'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {32'h0, result_m}, {32'h0, mon_e.res});
                chk("flags", {61'h0, eq_m, lt_m, ltu_m}, {61'h0, mon_e.flags});
                if (mon_e.lat >= 0) chk("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    task automatic run_suite();
        int   w;
        int   seen;
        exp_t e;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'h0, in_ready_m}, 64'h0);
        @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid_m}, 64'h0);
        chk("rst_result", {32'h0, result_m}, 64'h0);
        chk("rst_flags", {61'h0, eq_m, lt_m, ltu_m}, 64'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'h0, in_ready_m}, 64'h1);
        @(posedge clk);
        #2;

        issue(4'h2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, w);
        drain();

        issue(4'h6, 32'h5, 32'h5, 1'b1, w);
        issue(4'h8, 32'h8000_0000, 32'h1, 1'b1, w);
        chk("b2b_wait_slt", 64'(w), 64'h0);
        issue(4'h9, 32'h8000_0000, 32'h1, 1'b1, w);
        chk("b2b_wait_sltu", 64'(w), 64'h0);
        drain();

        issue(4'h7, 32'h8000_0000, 32'h4, 1'b1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("shift_in_ready", {63'h0, in_ready_m}, {63'h0, ~sel});
        end
        drain();
        issue(4'h5, 32'h8000_0000, 32'h4, 1'b1, w);
        issue(4'h4, 32'h1, 32'd31, 1'b1, w);
        drain();
        issue(4'h4, 32'hA5A5_0F0F, 32'h0000_0120, 1'b1, w);
        drain();

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            issue(4'($urandom_range(0, 15)), a, b, 1'b1, w);
        end
        drain();

        out_ready = 1'b0;
        issue(4'hA, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, w);
        e = model(4'hA, 32'h1234_5678, 32'hDEAD_BEEF, sel);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {63'h0, out_valid_m}, 64'h1);
            chk("bp_result", {32'h0, result_m}, {32'h0, e.res});
            chk("bp_flags", {61'h0, eq_m, lt_m, ltu_m}, {61'h0, e.flags});
            chk("bp_in_ready", {63'h0, in_ready_m}, 64'h0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        #1 chk("bp_release_ready", {63'h0, in_ready_m}, 64'h1);
        drain();

        out_ready = 1'b0;
        issue(4'h4, 32'h1, 32'd10, 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", {63'h0, in_ready_m}, 64'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_out_valid", {63'h0, out_valid_m}, 64'h0);
        chk("after_rst_result", {32'h0, result_m}, 64'h0);
        chk("after_rst_in_ready", {63'h0, in_ready_m}, 64'h1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid_m) seen++;
        end
        chk("no_stale_result", 64'(seen), 64'h0);
        @(posedge clk);
        #2;

        issue(4'hF, 32'hFFFF_FFFF, 32'h1, 1'b1, w);
        drain();
    endtask

    initial begin
        sel = 1'b1;
        run_suite();
        sel = 1'b0;
        run_suite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog (iter=%0d) got=timeout expected=finish", sel);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_pipelined.md
Name: alu_pipelined

Overview:
- Parametrised successor to the single-cycle combinational ALU in the execute stage.
- Operands are registered in one transaction at a time under a valid/ready handshake.
- Implements the full RV32I arithmetic set, including the previously missing SLL/SRL/SRA, SLT and SLTU.
- Produces registered branch-compare flags for the branch unit.
- Shifts run either as a one-cycle barrel shift or as an iterative 1-bit-per-cycle shifter, selected by parameter; the iterative form trades area for latency.

Parameters:
- WIDTH, 32: operand/result width. Power of two, ≥ 8.
- SHIFT_ITER, 0: 0 = barrel shifter (latency 1); 1 = iterative shifter (latency 1 + shamt).
- SHW, $clog2(WIDTH): shift-amount width. Derived; not overridden.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  operands/SELECT valid
- IN_READY  out  1  block can accept an operation this cycle
- DATA1  in  WIDTH  operand A
- DATA2  in  WIDTH  operand B; low SHW bits are the shift amount
- SELECT  in  4  opcode
- OUT_VALID  out  1  RESULT/flags valid
- OUT_READY  in  1  consumer accepts result
- RESULT  out  WIDTH  operation result
- EQ  out  1  DATA1 == DATA2 (captured operands)
- LT  out  1  signed DATA1 < DATA2
- LTU  out  1  unsigned DATA1 < DATA2

Behaviour:

Opcodes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASS (RESULT = DATA2).
- All other codes give RESULT = 0; EQ/LT/LTU are still valid.

Arithmetic rules:
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- SLT/SLTU yield 1 or 0, zero-extended to WIDTH.
- shamt = DATA2[SHW-1:0]; upper bits of DATA2 are ignored for shifts.
- SRA replicates DATA1[WIDTH-1].
- EQ/LT/LTU are computed from the captured operands for every opcode and registered alongside RESULT.

State machine (IDLE, SHIFT, DONE):
- IN_READY = !RESET && (state==IDLE || (state==DONE && OUT_READY)).
- IDLE, IN_VALID && IN_READY:
  - Capture operands and opcode.
  - Shift op with SHIFT_ITER=1 and shamt≠0: load the shift register with DATA1 and the counter with shamt; go to SHIFT.
  - Otherwise: compute RESULT and flags into output registers; go to DONE.
- SHIFT, per cycle:
  - Shift by 1 in the opcode's direction and decrement the counter.
  - When the counter reaches 1 the final shift is applied, RESULT loads, and next state is DONE.
  - IN_READY = 0 throughout.
- DONE:
  - OUT_VALID = 1. RESULT and flags are held stable until OUT_READY.
  - On OUT_READY: if a new op is accepted in the same cycle (IN_VALID), process it as from IDLE, so non-shift ops achieve one result per cycle; else go to IDLE and drop OUT_VALID.

Latency (acceptance edge to OUT_VALID high):
- Non-shift ops: 1 cycle.
- Shifts with SHIFT_ITER=0: 1 cycle.
- Shifts with SHIFT_ITER=1: 1 + shamt cycles; shamt = 0 gives 1.

Reset:
- Applies at the next CLK edge.
- State goes to IDLE; OUT_VALID, RESULT, EQ, LT, LTU and the counter go to 0; IN_READY is 0 while RESET is high.
- Reset mid-SHIFT or in DONE discards the operation; no OUT_VALID is produced.

Boundary conditions:
- IN_VALID while busy is ignored; the producer must hold it until IN_READY.
- OUT_READY while !OUT_VALID is ignored.
- Shift by WIDTH-1 is legal; shamt cannot reach WIDTH.
- Inputs X while IN_VALID = 0 must not affect state.

Test Plan:
1. WIDTH=32: ADD 0xFFFFFFFF + 0x00000002 -> RESULT 0x00000001 one cycle after acceptance, EQ=0, LT=1 (-1 < 2), LTU=0.
2. SUB 5-5, then SLT 0x80000000 vs 1, SLTU same operands, each op issued back-to-back with OUT_READY=1 -> RESULT 0, 1, 0 on consecutive cycles; EQ=1 on the first; IN_READY stays 1.
3. SHIFT_ITER=1: SRA 0x80000000 by 4 -> OUT_VALID exactly 5 cycles after acceptance, RESULT 0xF8000000, IN_READY=0 for the 4 SHIFT cycles. SRL same operands -> 0x08000000. SLL 0x1 by 31 -> 0x80000000 after 32 cycles.
4. SLL with DATA2=0x00000120 (shamt=0) -> RESULT = DATA1 after 1 cycle in both SHIFT_ITER modes.
5. Backpressure: hold OUT_READY=0 for 3 cycles after PASS 0xDEADBEEF -> OUT_VALID, RESULT and flags stable, IN_READY=0; release -> accepted, IN_READY=1 same cycle.
6. Assert RESET during the 3rd SHIFT cycle of SLL by 10 -> next edge OUT_VALID=0, RESULT=0, IN_READY=1 after deassertion; no stale result appears. Opcode 1111 -> RESULT 0.
